posmap_recursion_sequencer: RTL and testbench

Frontend controller that drives the PosMap/PLB lookup unit through one recursive position-map walk per program request. It issues PosMap updates from the data level upward until one hits, then walks back down. At each level on the way down it fetches the PosMap block from the ORAM backend, refills the PLB (writing back any eviction) and re-issues the update. When the data-level entry finally hits, it delivers the data block's old and new leaves downstream.

---
 rtl/posmap_recursion_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_posmap_recursion_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posmap_recursion_sequencer.sv
// Sequences one recursive PosMap walk per request: climb with updates until a hit,
// then descend level by level fetching, refilling and writing back PLB evictions.
module posmap_recursion_sequencer #(
    parameter int unsigned ORAMU          = 32,
    parameter int unsigned ORAML          = 20,
    parameter int unsigned LogLeafInBlock = 4,
    parameter int unsigned Levels         = 3,
    parameter logic [Levels*ORAMU-1:0] LevelStart = {32'h110000, 32'h100000, 32'h0}
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic             ReqWrite,
    input  logic [ORAMU-1:0] ReqAddr,
    output logic             PPPCmdValid,
    input  logic             PPPCmdReady,
    output logic [1:0]       PPPCmd,
    output logic [ORAMU-1:0] PPPAddr,
    input  logic             PPPValid,
    output logic             PPPOutReady,
    input  logic             PPPHit,
    input  logic             PPPUnInit,
    input  logic             PPPEvict,
    input  logic [ORAML-1:0] PPPOldLeaf,
    input  logic [ORAML-1:0] PPPNewLeaf,
    input  logic [ORAMU-1:0] PPPAddrOut,
    output logic             BEReqValid,
    input  logic             BEReqReady,
    output logic             BEKind,
    output logic [ORAMU-1:0] BEAddr,
    output logic [ORAML-1:0] BEOldLeaf,
    output logic [ORAML-1:0] BENewLeaf,
    output logic             BEUnInit,
    input  logic             BEDone,
    output logic             DoneValid,
    input  logic             DoneReady,
    output logic             DoneWrite,
    output logic [ORAMU-1:0] DoneAddr,
    output logic [ORAML-1:0] DoneOldLeaf,
    output logic [ORAML-1:0] DoneNewLeaf,
    output logic             DoneUnInit,
    output logic             Error
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOOK, S_LRESP, S_FETCH, S_RCMD, S_RWAIT, S_WB, S_WBWAIT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       lvl_q, lvl_d, hit_lvl_q, hit_lvl_d;
    logic             write_q, write_d, uninit_q, uninit_d;
    logic [ORAMU-1:0] addr_q, addr_d, evict_addr_q, evict_addr_d;
    logic [ORAML-1:0] old_leaf_q, old_leaf_d, new_leaf_q, new_leaf_d;
    logic [ORAML-1:0] evict_leaf_q, evict_leaf_d;
    logic             evict_q, evict_d, pv_seen_q, pv_seen_d, bd_seen_q, bd_seen_d;
    logic             error_q, error_d;
    logic [ORAMU-1:0] la_cur, la_hit, la_child;

    function automatic logic [ORAMU-1:0] level_addr(input logic [2:0] k,
                                                    input logic [ORAMU-1:0] a);
        level_addr = '0;
        for (int unsigned i = 0; i < Levels; i++)
            if (k == 3'(i))
                level_addr = LevelStart[i*ORAMU +: ORAMU] + (a >> (i*LogLeafInBlock));
    endfunction

    assign la_cur   = level_addr(lvl_q, addr_q);
    assign la_hit   = level_addr(hit_lvl_q, addr_q);
    assign la_child = level_addr(hit_lvl_q - 3'd1, addr_q);

    always_comb begin
        state_d      = state_q;
        lvl_d        = lvl_q;
        hit_lvl_d    = hit_lvl_q;
        write_d      = write_q;
        addr_d       = addr_q;
        uninit_d     = uninit_q;
        old_leaf_d   = old_leaf_q;
        new_leaf_d   = new_leaf_q;
        evict_d      = evict_q;
        evict_addr_d = evict_addr_q;
        evict_leaf_d = evict_leaf_q;
        pv_seen_d    = pv_seen_q;
        bd_seen_d    = bd_seen_q;
        ReqReady     = 1'b0;
        PPPCmdValid  = 1'b0;
        PPPOutReady  = 1'b0;
        BEReqValid   = 1'b0;
        DoneValid    = 1'b0;
        PPPCmd       = (state_q == S_RCMD) ? {1'b1, uninit_q} : 2'b00;
        PPPAddr      = (state_q == S_RCMD) ? la_child : la_cur;
        BEKind       = (state_q == S_WB);
        BEAddr       = (state_q == S_WB) ? evict_addr_q : la_hit;
        BEOldLeaf    = (state_q == S_WB) ? evict_leaf_q : old_leaf_q;
        BENewLeaf    = (state_q == S_WB) ? evict_leaf_q : new_leaf_q;
        BEUnInit     = (state_q == S_WB) ? 1'b0 : uninit_q;
        // Stray completions or responses mean the surrounding protocol is broken
        error_d      = error_q
                     | (BEDone && !(state_q == S_RWAIT || state_q == S_WBWAIT))
                     | (PPPValid && !(state_q == S_LRESP || state_q == S_RWAIT));

        case (state_q)
            S_IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    write_d = ReqWrite;
                    addr_d  = ReqAddr;
                    lvl_d   = '0;
                    state_d = S_LOOK;
                end
            end
            S_LOOK: begin
                PPPCmdValid = 1'b1;
                if (PPPCmdReady) state_d = S_LRESP;
            end
            S_LRESP: begin
                PPPOutReady = 1'b1;
                if (PPPValid) begin
                    if (PPPHit) begin
                        old_leaf_d = PPPOldLeaf;
                        new_leaf_d = PPPNewLeaf;
                        uninit_d   = PPPUnInit;
                        hit_lvl_d  = lvl_q;
                        state_d    = (lvl_q == '0) ? S_DONE : S_FETCH;
                    end else if (lvl_q == 3'(Levels - 1)) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        lvl_d   = lvl_q + 3'd1;
                        state_d = S_LOOK;
                    end
                end
            end
            S_FETCH: begin
                BEReqValid = 1'b1;
                if (BEReqReady) state_d = S_RCMD;
            end
            S_RCMD: begin
                PPPCmdValid = 1'b1;
                if (PPPCmdReady) begin
                    pv_seen_d = 1'b0;
                    bd_seen_d = 1'b0;
                    state_d   = S_RWAIT;
                end
            end
            S_RWAIT: begin
                PPPOutReady = 1'b1;
                if (PPPValid) begin
                    pv_seen_d    = 1'b1;
                    evict_d      = PPPEvict;
                    evict_addr_d = PPPAddrOut;
                    evict_leaf_d = PPPNewLeaf;
                end
                if (BEDone) bd_seen_d = 1'b1;
                if (pv_seen_d && bd_seen_d) begin
                    if (evict_d) begin
                        state_d = S_WB;
                    end else begin
                        lvl_d   = hit_lvl_q - 3'd1;
                        state_d = S_LOOK;
                    end
                end
            end
            S_WB: begin
                BEReqValid = 1'b1;
                if (BEReqReady) state_d = S_WBWAIT;
            end
            S_WBWAIT: begin
                if (BEDone) begin
                    lvl_d   = hit_lvl_q - 3'd1;
                    state_d = S_LOOK;
                end
            end
            S_DONE: begin
                DoneValid = 1'b1;
                if (DoneReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign DoneWrite   = write_q;
    assign DoneAddr    = addr_q;
    assign DoneOldLeaf = old_leaf_q;
    assign DoneNewLeaf = new_leaf_q;
    assign DoneUnInit  = uninit_q;
    assign Error       = error_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            lvl_q        <= '0;
            hit_lvl_q    <= '0;
            write_q      <= '0;
            addr_q       <= '0;
            uninit_q     <= '0;
            old_leaf_q   <= '0;
            new_leaf_q   <= '0;
            evict_q      <= '0;
            evict_addr_q <= '0;
            evict_leaf_q <= '0;
            pv_seen_q    <= '0;
            bd_seen_q    <= '0;
            error_q      <= '0;
        end else begin
            state_q      <= state_d;
            lvl_q        <= lvl_d;
            hit_lvl_q    <= hit_lvl_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            uninit_q     <= uninit_d;
            old_leaf_q   <= old_leaf_d;
            new_leaf_q   <= new_leaf_d;
            evict_q      <= evict_d;
            evict_addr_q <= evict_addr_d;
            evict_leaf_q <= evict_leaf_d;
            pv_seen_q    <= pv_seen_d;
            bd_seen_q    <= bd_seen_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_posmap_recursion_sequencer.sv
// Scoreboard bench: scenarios queue the expected command/backend/done transfers,
// an independent monitor pops and compares them as the DUT hands them over.
module tb_posmap_recursion_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid, ReqReady, ReqWrite;
    logic [31:0] ReqAddr;
    logic        PPPCmdValid, PPPCmdReady;
    logic [1:0]  PPPCmd;
    logic [31:0] PPPAddr;
    logic        PPPValid, PPPOutReady, PPPHit, PPPUnInit, PPPEvict;
    logic [19:0] PPPOldLeaf, PPPNewLeaf;
    logic [31:0] PPPAddrOut;
    logic        BEReqValid, BEReqReady, BEKind;
    logic [31:0] BEAddr;
    logic [19:0] BEOldLeaf, BENewLeaf;
    logic        BEUnInit, BEDone;
    logic        DoneValid, DoneReady, DoneWrite;
    logic [31:0] DoneAddr;
    logic [19:0] DoneOldLeaf, DoneNewLeaf;
    logic        DoneUnInit, Error;

    posmap_recursion_sequencer #(.ORAMU(32), .ORAML(20), .LogLeafInBlock(4), .Levels(3)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr),
        .PPPCmdValid(PPPCmdValid), .PPPCmdReady(PPPCmdReady), .PPPCmd(PPPCmd), .PPPAddr(PPPAddr),
        .PPPValid(PPPValid), .PPPOutReady(PPPOutReady), .PPPHit(PPPHit), .PPPUnInit(PPPUnInit),
        .PPPEvict(PPPEvict), .PPPOldLeaf(PPPOldLeaf), .PPPNewLeaf(PPPNewLeaf), .PPPAddrOut(PPPAddrOut),
        .BEReqValid(BEReqValid), .BEReqReady(BEReqReady), .BEKind(BEKind), .BEAddr(BEAddr),
        .BEOldLeaf(BEOldLeaf), .BENewLeaf(BENewLeaf), .BEUnInit(BEUnInit), .BEDone(BEDone),
        .DoneValid(DoneValid), .DoneReady(DoneReady), .DoneWrite(DoneWrite), .DoneAddr(DoneAddr),
        .DoneOldLeaf(DoneOldLeaf), .DoneNewLeaf(DoneNewLeaf), .DoneUnInit(DoneUnInit), .Error(Error)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [1:0]  kind;   // 0 lookup command, 1 backend request, 2 done
        logic [1:0]  cmd;
        logic        bek;
        logic [31:0] addr;
        logic [19:0] old_l;
        logic [19:0] new_l;
        logic        uninit;
        logic        wr;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  fails   = 0;
    int  cyc     = 0;
    int  t_req   = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic ev_t e_ppp(input logic [1:0] c, input logic [31:0] a);
        ev_t e = '0;
        e.kind = 2'd0; e.cmd = c; e.addr = a;
        return e;
    endfunction

    function automatic ev_t e_be(input logic k, input logic [31:0] a, input logic [19:0] o,
                                 input logic [19:0] n, input logic u);
        ev_t e = '0;
        e.kind = 2'd1; e.bek = k; e.addr = a; e.old_l = o; e.new_l = n; e.uninit = u;
        return e;
    endfunction

    function automatic ev_t e_done(input logic w, input logic [31:0] a, input logic [19:0] o,
                                   input logic [19:0] n, input logic u);
        ev_t e = '0;
        e.kind = 2'd2; e.wr = w; e.addr = a; e.old_l = o; e.new_l = n; e.uninit = u;
        return e;
    endfunction

    task automatic score(input string nm, input ev_t got);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_%s unexpected transfer: got kind=%0d cmd=%0d addr=%h, required none",
                     nm, got.kind, got.cmd, got.addr);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                fails++;
                $display("FAIL sb_%s got kind=%0d cmd=%0d bek=%0d addr=%h old=%h new=%h un=%0d wr=%0d required kind=%0d cmd=%0d bek=%0d addr=%h old=%h new=%h un=%0d wr=%0d",
                         nm, got.kind, got.cmd, got.bek, got.addr, got.old_l, got.new_l, got.uninit, got.wr,
                         e.kind, e.cmd, e.bek, e.addr, e.old_l, e.new_l, e.uninit, e.wr);
            end
        end
    endtask

    // Monitor: every accepted output transfer must match the next queued expectation
    always @(negedge Clock) begin
        if (!Reset) begin
            if (PPPCmdValid && PPPCmdReady) score("ppp", e_ppp(PPPCmd, PPPAddr));
            if (BEReqValid && BEReqReady) score("be", e_be(BEKind, BEAddr, BEOldLeaf, BENewLeaf, BEUnInit));
            if (DoneValid && DoneReady) score("done", e_done(DoneWrite, DoneAddr, DoneOldLeaf, DoneNewLeaf, DoneUnInit));
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h required %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic sig_now(input int sel);
        case (sel)
            0:       return PPPOutReady;
            1:       return BEReqValid;
            2:       return ReqReady;
            default: return DoneValid;
        endcase
    endfunction

    task automatic wait_sig(input int sel);
        int n = 0;
        while (!sig_now(sel) && n < 100) begin
            tick();
            n++;
        end
        if (!sig_now(sel)) begin
            vectors++;
            fails++;
            $display("FAIL wait_sel%0d timed out got 0 required 1", sel);
        end
    endtask

    task automatic send_req(input logic w, input logic [31:0] a);
        wait_sig(2);
        ReqValid = 1'b1; ReqWrite = w; ReqAddr = a;
        tick();
        t_req    = cyc;
        ReqValid = 1'b0;
    endtask

    task automatic lookup(input logic hit, input logic un, input logic [19:0] o, input logic [19:0] n);
        wait_sig(0);
        PPPValid = 1'b1; PPPHit = hit; PPPUnInit = un; PPPEvict = 1'b0;
        PPPOldLeaf = o; PPPNewLeaf = n;
        tick();
        PPPValid = 1'b0;
    endtask

    // order: 0 response and BEDone together, 1 BEDone first, 2 response first
    task automatic refill(input int order, input logic ev, input logic [31:0] aout, input logic [19:0] eleaf);
        wait_sig(1);
        tick();
        wait_sig(0);
        PPPHit = 1'b0; PPPUnInit = 1'b0; PPPEvict = ev; PPPAddrOut = aout; PPPNewLeaf = eleaf;
        if (order == 0) begin
            PPPValid = 1'b1; BEDone = 1'b1;
            tick();
            PPPValid = 1'b0; BEDone = 1'b0;
        end else if (order == 1) begin
            BEDone = 1'b1;
            tick();
            BEDone = 1'b0; PPPValid = 1'b1;
            tick();
            PPPValid = 1'b0;
        end else begin
            PPPValid = 1'b1;
            tick();
            PPPValid = 1'b0; BEDone = 1'b1;
            tick();
            BEDone = 1'b0;
        end
        if (ev) begin
            wait_sig(1);
            tick();
            BEDone = 1'b1;
            tick();
            BEDone = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0;
        PPPCmdReady = 1'b1; PPPValid = 1'b0; PPPHit = 1'b0; PPPUnInit = 1'b0; PPPEvict = 1'b0;
        PPPOldLeaf = '0; PPPNewLeaf = '0; PPPAddrOut = '0;
        BEReqReady = 1'b1; BEDone = 1'b0; DoneReady = 1'b1;
        tick(); tick(); tick();
        Reset = 1'b0;

        chk("rst_reqready", 32'(ReqReady), 32'd1);
        chk("rst_valids", {29'd0, PPPCmdValid, BEReqValid, DoneValid}, 32'd0);
        chk("rst_outready", 32'(PPPOutReady), 32'd0);
        chk("rst_error", 32'(Error), 32'd0);
        chk("rst_fields", {DoneOldLeaf[15:0], DoneNewLeaf[15:0]} | DoneAddr, 32'd0);

        // Level-0 hit, zero wait states
        exp_q.push_back(e_ppp(2'b00, 32'h5));
        exp_q.push_back(e_done(1'b1, 32'h5, 20'h11, 20'h22, 1'b0));
        send_req(1'b1, 32'h5);
        chk("l0_cmd_next_cycle", 32'(PPPCmdValid), 32'd1);
        lookup(1'b1, 1'b0, 20'h11, 20'h22);
        chk("l0_done_valid", 32'(DoneValid), 32'd1);
        chk("l0_done_latency", 32'(cyc - t_req), 32'd2);
        wait_sig(2);

        // Two-level miss; first descent evicts (BEDone with response), second BEDone first
        exp_q.push_back(e_ppp(2'b00, 32'h123));
        exp_q.push_back(e_ppp(2'b00, 32'h100012));
        exp_q.push_back(e_ppp(2'b00, 32'h110001));
        exp_q.push_back(e_be(1'b0, 32'h110001, 20'hA1, 20'hA2, 1'b0));
        exp_q.push_back(e_ppp(2'b10, 32'h100012));
        exp_q.push_back(e_be(1'b1, 32'h100040, 20'h5A, 20'h5A, 1'b0));
        exp_q.push_back(e_ppp(2'b00, 32'h100012));
        exp_q.push_back(e_be(1'b0, 32'h100012, 20'hB1, 20'hB2, 1'b0));
        exp_q.push_back(e_ppp(2'b10, 32'h123));
        exp_q.push_back(e_ppp(2'b00, 32'h123));
        exp_q.push_back(e_done(1'b0, 32'h123, 20'hC1, 20'hC2, 1'b0));
        send_req(1'b0, 32'h123);
        lookup(1'b0, 1'b0, 20'h0, 20'h0);
        lookup(1'b0, 1'b0, 20'h0, 20'h0);
        lookup(1'b1, 1'b0, 20'hA1, 20'hA2);
        refill(0, 1'b1, 32'h100040, 20'h5A);
        lookup(1'b1, 1'b0, 20'hB1, 20'hB2);
        refill(1, 1'b0, 32'h0, 20'h0);
        lookup(1'b1, 1'b0, 20'hC1, 20'hC2);
        wait_sig(2);
        chk("walk_no_error", 32'(Error), 32'd0);

        // UnInit hit at level 1, refill response first then BEDone, with eviction
        exp_q.push_back(e_ppp(2'b00, 32'h40));
        exp_q.push_back(e_ppp(2'b00, 32'h100004));
        exp_q.push_back(e_be(1'b0, 32'h100004, 20'h33, 20'h44, 1'b1));
        exp_q.push_back(e_ppp(2'b11, 32'h40));
        exp_q.push_back(e_be(1'b1, 32'h100040, 20'h55, 20'h55, 1'b0));
        exp_q.push_back(e_ppp(2'b00, 32'h40));
        exp_q.push_back(e_done(1'b1, 32'h40, 20'h66, 20'h77, 1'b0));
        send_req(1'b1, 32'h40);
        lookup(1'b0, 1'b0, 20'h0, 20'h0);
        lookup(1'b1, 1'b1, 20'h33, 20'h44);
        refill(2, 1'b1, 32'h100040, 20'h55);
        lookup(1'b1, 1'b0, 20'h66, 20'h77);
        wait_sig(2);
        chk("uninit_no_error", 32'(Error), 32'd0);

        // Done backpressure
        DoneReady = 1'b0;
        exp_q.push_back(e_ppp(2'b00, 32'h7));
        exp_q.push_back(e_done(1'b1, 32'h7, 20'h01, 20'h02, 1'b0));
        send_req(1'b1, 32'h7);
        lookup(1'b1, 1'b0, 20'h01, 20'h02);
        for (int i = 0; i < 5; i++) begin
            chk("bp_done_valid", 32'(DoneValid), 32'd1);
            chk("bp_done_addr", DoneAddr, 32'h7);
            chk("bp_done_leaves", {6'd0, DoneOldLeaf[12:0], DoneNewLeaf[12:0]}, {6'd0, 13'h01, 13'h02});
            chk("bp_req_ready", 32'(ReqReady), 32'd0);
            tick();
        end
        DoneReady = 1'b1;
        tick();
        chk("bp_released", 32'(ReqReady), 32'd1);

        // Reset while waiting in RWAIT
        exp_q.push_back(e_ppp(2'b00, 32'h10));
        exp_q.push_back(e_ppp(2'b00, 32'h100001));
        exp_q.push_back(e_be(1'b0, 32'h100001, 20'h1, 20'h2, 1'b0));
        exp_q.push_back(e_ppp(2'b10, 32'h10));
        send_req(1'b0, 32'h10);
        lookup(1'b0, 1'b0, 20'h0, 20'h0);
        lookup(1'b1, 1'b0, 20'h1, 20'h2);
        wait_sig(1);
        tick();
        wait_sig(0);
        Reset = 1'b1;
        tick();
        chk("midrst_reqready", 32'(ReqReady), 32'd1);
        chk("midrst_valids", {28'd0, PPPCmdValid, BEReqValid, DoneValid, PPPOutReady}, 32'd0);
        chk("midrst_fields", {12'd0, DoneOldLeaf | DoneNewLeaf}, 32'd0);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_quiet", 32'(PPPCmdValid), 32'd0);
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);

        // Miss at the top level is a protocol error
        exp_q.push_back(e_ppp(2'b00, 32'h1));
        exp_q.push_back(e_ppp(2'b00, 32'h100000));
        exp_q.push_back(e_ppp(2'b00, 32'h110000));
        send_req(1'b0, 32'h1);
        lookup(1'b0, 1'b0, 20'h0, 20'h0);
        lookup(1'b0, 1'b0, 20'h0, 20'h0);
        lookup(1'b0, 1'b0, 20'h0, 20'h0);
        chk("topmiss_error", 32'(Error), 32'd1);
        chk("topmiss_idle", 32'(ReqReady), 32'd1);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("topmiss_cleared", 32'(Error), 32'd0);

        // Spurious BEDone while idle
        BEDone = 1'b1;
        tick();
        BEDone = 1'b0;
        chk("spurious_error", 32'(Error), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("spurious_sticky", 32'(Error), 32'd1);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("spurious_cleared", 32'(Error), 32'd0);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
